// File: rtl/score_keeper.sv
// score_keeper: rhythm-game scoring with combo bonus, miss tally and timed rating display
//
// Ports
//   clk_i         single clock, all state on its rising edge
//   reset_n_i     asynchronous active-low reset
//   frame_i       one-cycle pulse per video frame (paces the rating display)
//   clear_i       synchronous song restart, overrides every event
//   judge_i       {marvelous, perfect, great, good}; any nonzero cycle is one hit
//   miss_i        one-cycle pulse per arrow that left the field unpressed
//   score_o       accumulated score, saturating
//   combo_o       current combo, saturating
//   max_combo_o   highest combo since the last clear
//   miss_count_o  misses since the last clear, saturating at 255
//   rating_o      displayed rating: 0 none, 1 good, 2 great, 3 perfect, 4 marvelous, 5 miss
module score_keeper #(
    parameter int SCOREW         = 16,
    parameter int COMBOW         = 10,
    parameter int PTS_MARV       = 8,
    parameter int PTS_PERF       = 5,
    parameter int PTS_GREAT      = 3,
    parameter int PTS_GOOD       = 1,
    parameter int BONUS_COMBO    = 50,
    parameter int DISPLAY_FRAMES = 30
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              frame_i,
    input  logic              clear_i,
    input  logic [3:0]        judge_i,
    input  logic              miss_i,
    output logic [SCOREW-1:0] score_o,
    output logic [COMBOW-1:0] combo_o,
    output logic [COMBOW-1:0] max_combo_o,
    output logic [7:0]        miss_count_o,
    output logic [2:0]        rating_o
);
    localparam int CW = $clog2(DISPLAY_FRAMES + 1);
    localparam logic [SCOREW:0]   P_MARV  = (SCOREW+1)'(PTS_MARV);
    localparam logic [SCOREW:0]   P_PERF  = (SCOREW+1)'(PTS_PERF);
    localparam logic [SCOREW:0]   P_GREAT = (SCOREW+1)'(PTS_GREAT);
    localparam logic [SCOREW:0]   P_GOOD  = (SCOREW+1)'(PTS_GOOD);
    localparam logic [COMBOW-1:0] BONUS   = COMBOW'(BONUS_COMBO);
    localparam logic [CW-1:0]     LOAD    = CW'(DISPLAY_FRAMES);
    localparam logic [2:0]        R_MISS  = 3'd5;

    typedef enum logic {DISP_IDLE, DISP_SHOW} disp_t;

    disp_t             state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        rating_q, rating_d;
    logic [SCOREW-1:0] score_q, score_d;
    logic [COMBOW-1:0] combo_q, combo_d;
    logic [COMBOW-1:0] max_q, max_d;
    logic [7:0]        miss_q, miss_d;

    logic              hit;
    logic [2:0]        hit_rating;
    logic [SCOREW:0]   base_pts, pts, sum;
    logic [SCOREW-1:0] score_sat;
    logic [COMBOW-1:0] combo_inc;
    logic [7:0]        miss_inc;

    // Hit decode, point value and saturating increments
    always_comb begin
        hit        = |judge_i;
        hit_rating = judge_i[3] ? 3'd4 : judge_i[2] ? 3'd3 : judge_i[1] ? 3'd2 : 3'd1;
        base_pts   = judge_i[3] ? P_MARV : judge_i[2] ? P_PERF : judge_i[1] ? P_GREAT : P_GOOD;
        // bonus keys off the combo before this hit is counted
        pts        = (combo_q >= BONUS) ? base_pts << 1 : base_pts;
        sum        = {1'b0, score_q} + pts;
        score_sat  = sum[SCOREW] ? '1 : sum[SCOREW-1:0];
        combo_inc  = &combo_q ? combo_q : combo_q + 1'b1;
        miss_inc   = &miss_q ? miss_q : miss_q + 8'd1;
    end

    // Score, combo and miss bookkeeping
    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        max_d   = max_q;
        miss_d  = miss_q;
        if (clear_i) begin
            score_d = '0;
            combo_d = '0;
            max_d   = '0;
            miss_d  = '0;
        end else begin
            if (hit) begin
                score_d = score_sat;
                combo_d = combo_inc;
                // a simultaneous miss still lets the hit's combo count toward the maximum
                if (combo_inc > max_q) max_d = combo_inc;
            end
            if (miss_i) begin
                combo_d = '0;
                miss_d  = miss_inc;
            end
        end
    end

    // Display FSM: any event (re)starts the display, frames count it down
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rating_d = rating_q;
        if (clear_i) begin
            state_d  = DISP_IDLE;
            cnt_d    = '0;
            rating_d = '0;
        end else if (hit || miss_i) begin
            state_d  = DISP_SHOW;
            cnt_d    = LOAD;
            rating_d = hit ? hit_rating : R_MISS;
        end else if (state_q == DISP_SHOW && frame_i) begin
            if (cnt_q == CW'(1)) begin
                state_d  = DISP_IDLE;
                cnt_d    = '0;
                rating_d = '0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= DISP_IDLE;
            cnt_q    <= '0;
            rating_q <= '0;
            score_q  <= '0;
            combo_q  <= '0;
            max_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rating_q <= rating_d;
            score_q  <= score_d;
            combo_q  <= combo_d;
            max_q    <= max_d;
            miss_q   <= miss_d;
        end
    end

    assign score_o      = score_q;
    assign combo_o      = combo_q;
    assign max_combo_o  = max_q;
    assign miss_count_o = miss_q;
    assign rating_o     = rating_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed checks of score_keeper against a behavioural model
module tb_score_keeper;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame = 1'b0;
    logic        clear = 1'b0;
    logic        miss = 1'b0;
    logic [3:0]  judge = 4'd0;
    logic [15:0] score;
    logic [9:0]  combo, max_combo;
    logic [7:0]  miss_count;
    logic [2:0]  rating;

    int compared = 0;
    int mismatched = 0;
    bit cmp_en = 1'b0;

    int m_score = 0, m_combo = 0, m_max = 0, m_miss = 0, m_rating = 0, m_rem = 0;

    score_keeper dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .frame_i(frame),
        .clear_i(clear),
        .judge_i(judge),
        .miss_i(miss),
        .score_o(score),
        .combo_o(combo),
        .max_combo_o(max_combo),
        .miss_count_o(miss_count),
        .rating_o(rating)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: plain integer arithmetic with min() saturation
    always @(posedge clk or negedge reset_n) begin : model
        int r, p;
        if (!reset_n || clear) begin
            m_score = 0; m_combo = 0; m_max = 0; m_miss = 0; m_rating = 0; m_rem = 0;
        end else begin
            r = judge[3] ? 4 : judge[2] ? 3 : judge[1] ? 2 : 1;
            p = (r == 4) ? 8 : (r == 3) ? 5 : (r == 2) ? 3 : 1;
            if (m_combo >= 50) p = p * 2;
            if (judge != 0) begin
                m_score = (m_score + p > 65535) ? 65535 : m_score + p;
                m_combo = (m_combo + 1 > 1023) ? 1023 : m_combo + 1;
                if (m_combo > m_max) m_max = m_combo;
            end
            if (miss) begin
                m_combo = 0;
                m_miss = (m_miss + 1 > 255) ? 255 : m_miss + 1;
            end
            if (judge != 0 || miss) begin
                m_rating = (judge != 0) ? r : 5;
                m_rem = 30;
            end else if (m_rem > 0 && frame) begin
                m_rem--;
                if (m_rem == 0) m_rating = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("score", int'(score), m_score);
            chk("combo", int'(combo), m_combo);
            chk("max_combo", int'(max_combo), m_max);
            chk("miss_count", int'(miss_count), m_miss);
            chk("rating", int'(rating), m_rating);
        end
    end

    task automatic step(input logic [3:0] j, input logic m, input logic f, input logic c);
        judge = j; miss = m; frame = f; clear = c;
        @(posedge clk);
        #1;
        judge = 4'd0; miss = 1'b0; frame = 1'b0; clear = 1'b0;
    endtask

    task automatic chk_all(input string name, input int s, input int c, input int mx, input int ms, input int r);
        chk({name, "_score"}, int'(score), s);
        chk({name, "_combo"}, int'(combo), c);
        chk({name, "_max"}, int'(max_combo), mx);
        chk({name, "_miss"}, int'(miss_count), ms);
        chk({name, "_rating"}, int'(rating), r);
    endtask

    initial begin
        #7;
        chk_all("reset", 0, 0, 0, 0, 0);
        #5 reset_n = 1'b1;
        cmp_en = 1'b1;

        step(4'b1000, 0, 0, 0);
        chk_all("marv_first", 8, 1, 1, 0, 4);
        step(4'b0110, 0, 0, 0);
        chk_all("perf_multi", 13, 2, 2, 0, 3);

        step(0, 0, 0, 1);
        for (int i = 0; i < 50; i++) step(4'b0001, 0, 0, 0);
        chk("combo50_score", int'(score), 50);
        step(4'b0001, 0, 0, 0);
        chk("bonus_good", int'(score), 52);

        step(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(4'b0001, 0, 0, 0);
        step(4'b0010, 1, 0, 0);
        chk_all("hit_and_miss", 10, 0, 8, 1, 2);

        step(0, 0, 0, 1);
        step(4'b0001, 0, 0, 0);
        for (int i = 1; i <= 30; i++) begin
            step(0, 0, 1, 0);
            chk("disp_countdown", int'(rating), (i < 30) ? 1 : 0);
            step(0, 0, 0, 0);
        end
        step(0, 0, 1, 0);
        chk("idle_ignores_frame", int'(rating), 0);

        step(0, 0, 0, 1);
        step(4'b0001, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 1, 0);
        step(4'b0010, 0, 1, 0);
        chk("reload_rating", int'(rating), 2);
        for (int i = 1; i <= 30; i++) begin
            step(0, 0, 1, 0);
            chk("reload_countdown", int'(rating), (i < 30) ? 2 : 0);
        end

        step(0, 0, 0, 1);
        while (m_score + ((m_combo >= 50) ? 16 : 8) <= 65534) step(4'b1000, 0, 0, 0);
        while (m_score + 2 <= 65534) step(4'b0001, 0, 0, 0);
        chk("score_65534", int'(score), 65534);
        chk("combo_sat", int'(combo), 1023);
        step(4'b1000, 0, 0, 0);
        chk("score_sat", int'(score), 65535);
        step(4'b1000, 0, 0, 0);
        chk("score_sat_hold", int'(score), 65535);
        for (int i = 0; i < 260; i++) step(0, 1, 0, 0);
        chk("miss_sat", int'(miss_count), 255);
        chk("max_after_miss", int'(max_combo), 1023);
        step(4'b1000, 1, 1, 1);
        chk_all("clear_wins", 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 99) == 0);
        end

        step(0, 0, 0, 1);
        step(4'b0100, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 chk_all("async_reset", 0, 0, 0, 0, 0);
        #3 reset_n = 1'b1;
        step(4'b0001, 0, 0, 0);
        chk_all("after_reset", 1, 1, 1, 0, 1);
        step(0, 0, 0, 0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter SCOREW, 16, score width in bits.
REQ-002 SHALL have parameter COMBOW, 10, combo and max-combo width in bits.
REQ-003 SHALL have parameters PTS_MARV 8, PTS_PERF 5, PTS_GREAT 3, PTS_GOOD 1, giving the points per rating.
REQ-004 SHALL have parameter BONUS_COMBO, 50, the combo threshold at which points are doubled.
REQ-005 SHALL have parameter DISPLAY_FRAMES, 30, the number of frames a rating stays displayed.
REQ-006 SHALL have port clk_i, input, 1, the single clock; one clock, all state on its rising edge.
REQ-007 SHALL have port reset_n_i, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port frame_i, input, 1, a one-cycle pulse per video frame.
REQ-009 SHALL have port clear_i, input, 1, a synchronous song restart.
REQ-010 SHALL have port judge_i, input, 4, {marvelous, perfect, great, good} from the arrow judging stage.
REQ-011 SHALL have port miss_i, input, 1, a one-cycle pulse per arrow that left the field unpressed.
REQ-012 SHALL have port score_o, output, SCOREW, the accumulated score.
REQ-013 SHALL have port combo_o, output, COMBOW, the current combo.
REQ-014 SHALL have port max_combo_o, output, COMBOW, the highest combo this song.
REQ-015 SHALL have port miss_count_o, output, 8, the number of misses.
REQ-016 SHALL have port rating_o, output, 3, the displayed rating: 0 none, 1 good, 2 great, 3 perfect, 4 marvelous, 5 miss.

Function
REQ-017 SHALL treat every cycle with judge_i != 0 as exactly one hit; back-to-back nonzero cycles are separate hits, with no edge detection.
REQ-018 SHALL resolve multiple set judge_i bits to the highest set bit (marvelous > perfect > great > good).
REQ-019 SHALL compute hit points as the rating's PTS value, doubled when combo_o (pre-update value) >= BONUS_COMBO.
REQ-020 SHALL add hit points to score_o one cycle after the hit (latency 1), saturating at 2^SCOREW-1.
REQ-021 SHALL increment combo_o on a hit, saturating at 2^COMBOW-1.
REQ-022 SHALL set max_combo_o to the new combo whenever the new combo exceeds max_combo_o, in the same cycle as the combo update.
REQ-023 SHALL on miss_i set combo_o to 0 and increment miss_count_o, saturating at 255; max_combo_o is unchanged.
REQ-024 SHALL on a hit and miss_i in the same cycle add the hit points (bonus evaluated on pre-update combo), set combo_o to 0, increment miss_count_o, and compare max_combo_o against pre-update combo+1.
REQ-025 SHALL give clear_i priority over all events: score_o, combo_o, max_combo_o, miss_count_o and rating_o go to 0, the display FSM goes to DISP_IDLE, and the hit/miss is discarded.
REQ-026 SHALL implement a display FSM with two states, DISP_IDLE and DISP_SHOW, plus a frame counter of width clog2(DISPLAY_FRAMES+1).
REQ-027 SHALL on any hit or miss, from either state, go to DISP_SHOW, load rating_o (hit rating wins over miss when simultaneous), and load the counter with DISPLAY_FRAMES.
REQ-028 SHALL in DISP_SHOW decrement the counter on each frame_i; a frame_i with counter == 1 goes to DISP_IDLE with rating_o = 0 in the next cycle.
REQ-029 SHALL let an event reload win over frame_i when both occur in the same cycle.
REQ-030 SHALL in DISP_IDLE hold rating_o at 0 and ignore frame_i.
REQ-031 SHALL drive all outputs directly from registers.

Reset
REQ-032 SHALL on reset_n_i low asynchronously set score_o, combo_o, max_combo_o, miss_count_o, rating_o and the frame counter to 0, and the FSM to DISP_IDLE.
REQ-033 SHALL resume normal operation on the first rising clk_i edge after reset_n_i deasserts; a reset mid-display discards the display.

Verification
REQ-034 SHALL verify: judge_i=4'b1000 for 1 cycle from reset -> next cycle score_o=8, combo_o=1, max_combo_o=1, rating_o=4.
REQ-035 SHALL verify: judge_i=4'b0110 for 1 cycle -> score +5, rating_o=3; and with combo_o=50 a judge_i=4'b0001 -> score +2.
REQ-036 SHALL verify: combo_o=7, then hit and miss_i in the same cycle -> combo_o=0, miss_count_o +1, max_combo_o=8, rating_o=rating of the hit.
REQ-037 SHALL verify: one hit then 30 frame_i pulses -> rating_o nonzero through the 29th pulse and 0 after the 30th; a hit coincident with the 15th pulse -> counter reloads to 30.
REQ-038 SHALL verify: score_o=65534 plus a marvelous hit -> score_o=65535; clear_i coincident with a hit -> all outputs 0.
REQ-039 SHALL verify: reset_n_i asserted mid-DISP_SHOW without a clock edge -> all outputs 0 immediately.
